quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 115 +++++++++++
 tb/tb_quad_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder. Both channels are synchronized and glitch-filtered,
// then each accepted Gray-code step moves a modulo-N position counter.
module quad_decoder #(
    parameter int N    = 7,
    parameter int K    = 3,
    parameter int FILT = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_a,
    input  logic         i_b,
    input  logic         i_clr,
    output logic [K-1:0] o_Q,
    output logic         o_en,
    output logic         o_up_down,
    output logic         o_wrap,
    output logic         o_err
);

    localparam logic [K-1:0] Q_MAX   = K'(N - 1);
    localparam logic [K-1:0] Q_ONE   = K'(1);
    localparam logic [3:0]   FILT_M1 = 4'(FILT - 1);

    // Channel vectors: bit 1 = A, bit 0 = B.
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] f;
    logic [1:0] f_nxt;
    logic [3:0] cnt     [2];
    logic [3:0] cnt_nxt [2];
    logic [1:0] arm;
    logic       armed;
    logic [1:0] dir;
    logic       step_up;
    logic       step_dn;
    logic       step_bad;

    // Position along the 00->01->11->10 cycle, so a forward step is +1 mod 4.
    function automatic logic [1:0] gray_idx(input logic [1:0] v);
        return {v[1], v[1] ^ v[0]};
    endfunction

    // Modulo-N increment with wrap at N-1.
    function automatic logic [K-1:0] q_inc(input logic [K-1:0] q);
        return (q == Q_MAX) ? '0 : q + Q_ONE;
    endfunction

    // Modulo-N decrement with wrap at 0.
    function automatic logic [K-1:0] q_dec(input logic [K-1:0] q);
        return (q == '0) ? Q_MAX : q - Q_ONE;
    endfunction

    assign armed = (arm == 2'd3);

    // Per-channel glitch filter and the step decode of the filtered pair.
    // A level is accepted only when s1 agrees with s2 as well, so the new
    // level has been sampled on FILT+1 consecutive edges before f moves.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            f_nxt[ch]   = f[ch];
            cnt_nxt[ch] = 4'd0;
            if (!armed) begin
                f_nxt[ch] = s2[ch];
            end else if (s2[ch] != f[ch]) begin
                if (cnt[ch] == FILT_M1 && s1[ch] == s2[ch]) begin
                    f_nxt[ch] = s2[ch];
                end else begin
                    cnt_nxt[ch] = cnt[ch] + 4'd1;
                end
            end
        end
        dir      = gray_idx(f_nxt) - gray_idx(f);
        step_up  = armed && (dir == 2'd1);
        step_dn  = armed && (dir == 2'd3);
        step_bad = armed && (dir == 2'd2);
    end

    // Synchronizers, filter state, arming counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1        <= '0;
            s2        <= '0;
            f         <= '0;
            for (int ch = 0; ch < 2; ch++) cnt[ch] <= 4'd0;
            arm       <= 2'd0;
            o_Q       <= '0;
            o_en      <= 1'b0;
            o_up_down <= 1'b1;
            o_wrap    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            s1 <= {i_a, i_b};
            s2 <= s1;
            f  <= f_nxt;
            for (int ch = 0; ch < 2; ch++) cnt[ch] <= cnt_nxt[ch];
            if (!armed) arm <= arm + 2'd1;

            o_en   <= step_up | step_dn;
            o_err  <= step_bad;
            o_wrap <= 1'b0;
            if (step_up | step_dn) o_up_down <= step_up;

            if (i_clr) begin
                o_Q <= '0;
            end else if (step_up) begin
                o_Q    <= q_inc(o_Q);
                o_wrap <= (o_Q == Q_MAX);
            end else if (step_dn) begin
                o_Q    <= q_dec(o_Q);
                o_wrap <= (o_Q == '0);
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios followed by random quadrature
// traffic, all checked against a cycle-level reference model.
module tb_quad_decoder;

    localparam int N    = 7;
    localparam int K    = 3;
    localparam int FILT = 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_a   = 1'b0;
    logic         i_b   = 1'b0;
    logic         i_clr = 1'b0;
    logic [K-1:0] o_Q;
    logic         o_en;
    logic         o_up_down;
    logic         o_wrap;
    logic         o_err;

    quad_decoder #(.N(N), .K(K), .FILT(FILT)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_clr    (i_clr),
        .o_Q      (o_Q),
        .o_en     (o_en),
        .o_up_down(o_up_down),
        .o_wrap   (o_wrap),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int en_seen  = 0;
    int err_seen = 0;

    // Reference model state.
    logic [1:0] mf;
    logic [1:0] hist[$];
    int         mq;
    logic       mup;
    logic       m_en;
    logic       m_wrap;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
            $error("check %s", tag);
        end
    endtask

    // Place on the 00->01->11->10 forward cycle.
    function automatic int cyc_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // One clock edge of the model. A filtered channel flips once its last
    // FILT+1 samples (edges before this one) all disagree with it.
    task automatic model_edge(input logic [1:0] in, input logic clr, input logic rst);
        logic [1:0] nf;
        int d;
        if (rst) begin
            mq = 0; mup = 1'b1; m_en = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
            mf = in;
            hist.delete();
            for (int i = 0; i <= FILT; i++) hist.push_back(in);
            return;
        end
        nf = mf;
        for (int ch = 0; ch < 2; ch++) begin
            bit all_new = 1'b1;
            for (int i = 0; i <= FILT; i++)
                if (hist[hist.size() - 1 - i][ch] == mf[ch]) all_new = 1'b0;
            if (all_new) nf[ch] = ~mf[ch];
        end
        hist.push_back(in);
        if (hist.size() > 16) void'(hist.pop_front());
        d = (cyc_pos(nf) - cyc_pos(mf) + 4) % 4;
        mf = nf;
        m_en = (d == 1 || d == 3);
        m_err = (d == 2);
        m_wrap = 1'b0;
        if (m_en) mup = (d == 1);
        if (clr) begin
            mq = 0;
        end else if (d == 1) begin
            m_wrap = (mq == N - 1);
            mq = (mq + 1) % N;
        end else if (d == 3) begin
            m_wrap = (mq == 0);
            mq = (mq + N - 1) % N;
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every output.
    task automatic cyc(input logic [1:0] ab, input logic clr, input logic rst);
        i_a = ab[1]; i_b = ab[0]; i_clr = clr; i_rst = rst;
        @(posedge i_clk);
        model_edge(ab, clr, rst);
        #1;
        chk("o_Q",       {29'd0, o_Q}, mq);
        chk("o_en",      {31'd0, o_en}, {31'd0, m_en});
        chk("o_up_down", {31'd0, o_up_down}, {31'd0, mup});
        chk("o_wrap",    {31'd0, o_wrap}, {31'd0, m_wrap});
        chk("o_err",     {31'd0, o_err}, {31'd0, m_err});
        if (o_en === 1'b1) en_seen++;
        if (o_err === 1'b1) err_seen++;
        @(negedge i_clk);
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        for (int i = 0; i < n; i++) cyc(ab, 1'b0, 1'b0);
    endtask

    initial begin
        int en0;
        int err0;
        logic [1:0] cur;

        // Reset with both channels high, then let arming finish.
        for (int i = 0; i < 3; i++) cyc(2'b11, 1'b0, 1'b1);
        chk("rst_q", {29'd0, o_Q}, 32'd0);
        chk("rst_up", {31'd0, o_up_down}, 32'd1);
        hold(2'b11, 8);
        chk("arm_q", {29'd0, o_Q}, 32'd0);
        chk("arm_err_none", err_seen, 32'd0);
        chk("arm_up", {31'd0, o_up_down}, 32'd1);

        // Four forward steps.
        hold(2'b10, 10); chk("fwd1_q", {29'd0, o_Q}, 32'd1);
        hold(2'b00, 10); chk("fwd2_q", {29'd0, o_Q}, 32'd2);
        hold(2'b01, 10); chk("fwd3_q", {29'd0, o_Q}, 32'd3);
        hold(2'b11, 10); chk("fwd4_q", {29'd0, o_Q}, 32'd4);
        chk("fwd_en_cnt", en_seen, 32'd4);
        chk("fwd_up", {31'd0, o_up_down}, 32'd1);

        // Reach 6, then wrap up to 0 and back down to 6.
        hold(2'b10, 10);
        hold(2'b00, 10);
        chk("at6_q", {29'd0, o_Q}, 32'd6);
        hold(2'b01, 3);
        chk("lat_no_en_yet", {31'd0, o_en}, 32'd0);
        cyc(2'b01, 1'b0, 1'b0);
        chk("wrapup_en", {31'd0, o_en}, 32'd1);
        chk("wrapup_wrap", {31'd0, o_wrap}, 32'd1);
        chk("wrapup_q", {29'd0, o_Q}, 32'd0);
        hold(2'b01, 6);
        hold(2'b00, 3);
        cyc(2'b00, 1'b0, 1'b0);
        chk("wrapdn_en", {31'd0, o_en}, 32'd1);
        chk("wrapdn_wrap", {31'd0, o_wrap}, 32'd1);
        chk("wrapdn_q", {29'd0, o_Q}, 32'd6);
        chk("wrapdn_dir", {31'd0, o_up_down}, 32'd0);
        hold(2'b00, 6);

        // Short glitch on A is rejected; a FILT+1 pulse is accepted.
        en0 = en_seen;
        hold(2'b10, 2);
        hold(2'b00, 10);
        chk("glitch_no_en", en_seen - en0, 32'd0);
        chk("glitch_q", {29'd0, o_Q}, 32'd6);
        hold(2'b10, 3);
        hold(2'b00, 10);
        chk("pulse_en_cnt", en_seen - en0, 32'd2);
        chk("pulse_q", {29'd0, o_Q}, 32'd6);

        // Both channels change together: one error, no movement.
        err0 = err_seen;
        hold(2'b11, 10);
        chk("dbl_err_cnt", err_seen - err0, 32'd1);
        chk("dbl_q", {29'd0, o_Q}, 32'd6);
        chk("dbl_up", {31'd0, o_up_down}, 32'd1);

        // Clear on the decode edge of a step that would otherwise wrap.
        hold(2'b10, 3);
        cyc(2'b10, 1'b1, 1'b0);
        chk("clr_q", {29'd0, o_Q}, 32'd0);
        chk("clr_en", {31'd0, o_en}, 32'd1);
        chk("clr_wrap", {31'd0, o_wrap}, 32'd0);
        hold(2'b10, 6);

        // Reset while a step is still being filtered.
        hold(2'b00, 2);
        en0 = en_seen;
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b1);
        hold(2'b00, 10);
        chk("rstmid_q", {29'd0, o_Q}, 32'd0);
        chk("rstmid_no_en", en_seen - en0, 32'd0);

        // Random quadrature traffic with occasional double changes and clears.
        cur = 2'b00;
        for (int n = 0; n < 150; n++) begin
            int len = $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) cur = cur ^ 2'b11;
            else if ($urandom_range(0, 1) == 0) cur = cur ^ 2'b01;
            else cur = cur ^ 2'b10;
            for (int i = 0; i < len; i++)
                cyc(cur, ($urandom_range(0, 15) == 0), 1'b0);
        end
        hold(cur, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
